barret_pipe: RTL and testbench

BARRET_PIPE -- requirements
Module: barret_pipe

---
 rtl/barret_pkg.sv | 21 ++
 rtl/barret_pipe_stage.sv | 44 ++++
 rtl/barret_pipe.sv | 129 ++++++++++++
 tb/tb_barret_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barret_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reduction pipe.
// MU and the result width are derived from the modulus and operand width.
package barret_pkg;

  localparam int unsigned Q_DEFAULT     = 3187;
  localparam int unsigned DIN_W_DEFAULT = 23;

  function automatic int unsigned calc_dout_w(input int unsigned q);
    return $clog2(q);
  endfunction

  function automatic logic [63:0] calc_mu(
    input int unsigned q,
    input int unsigned din_w
  );
    logic [63:0] one;
    one = 64'd1;
    return (one << din_w) / 64'(q);
  endfunction

endpackage

// File: rtl/barret_pipe_stage.sv
// One valid/ready pipeline register; loads whenever it is empty or drains.
// Ready is combinational on the downstream ready so bubbles collapse.
module barret_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next state: take the upstream beat whenever this slot frees up.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  // Slot register; reset drops any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/barret_pipe.sv
// Three-stage Barrett reduction: x mod Q with a tag riding alongside.
// S1 multiplies by MU, S2 forms the coarse residue, S3 corrects it.
module barret_pipe
  import barret_pkg::*;
#(
  parameter int unsigned Q     = Q_DEFAULT,
  parameter int unsigned DIN_W = DIN_W_DEFAULT,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned DOUT_W = calc_dout_w(Q)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DIN_W-1:0]  din_a,
  input  logic [TAG_W-1:0]  din_tag,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DOUT_W-1:0] dout_r,
  output logic [TAG_W-1:0]  dout_tag,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int unsigned PW = 2 * DIN_W;
  localparam int unsigned RW = DOUT_W + 2;
  localparam int unsigned W1 = PW + DIN_W + TAG_W;
  localparam int unsigned W2 = RW + TAG_W;
  localparam int unsigned W3 = DOUT_W + TAG_W;

  localparam logic [DIN_W-1:0] MU = DIN_W'(calc_mu(Q, DIN_W));
  localparam logic [RW-1:0]    QV = RW'(Q);

  logic              s1_rdy, s1_valid;
  logic              s2_rdy, s2_valid;
  logic              s3_rdy;
  logic [W1-1:0]     s1_data;
  logic [W2-1:0]     s2_data;
  logic [W3-1:0]     s3_data;

  logic [PW-1:0]     p_d;
  logic [PW-1:0]     s1_p;
  logic [DIN_W-1:0]  s1_x;
  logic [TAG_W-1:0]  s1_tag;

  logic [PW-1:0]     q_full;
  logic [RW-1:0]     q_t, x_t, r0_d;
  logic [RW-1:0]     s2_r0;
  logic [TAG_W-1:0]  s2_tag;

  logic [RW-1:0]     t1, t2;
  logic [DOUT_W-1:0] r_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign p_d = PW'(din_a) * PW'(MU);

  barret_stage #(.W(W1)) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (din_valid),
    .in_ready_o  (s1_rdy),
    .in_data_i   ({p_d, din_a, din_tag}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_rdy),
    .out_data_o  (s1_data)
  );

  assign din_ready = rst_n & s1_rdy;
  assign {s1_p, s1_x, s1_tag} = s1_data;

  // Coarse residue; true value is below 2Q so RW-bit wraparound is exact.
  always_comb begin
    q_full = s1_p >> DIN_W;
    q_t    = RW'(q_full);
    x_t    = RW'(s1_x);
    r0_d   = x_t - q_t * QV;
  end

  barret_stage #(.W(W2)) u_s2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_rdy),
    .in_data_i   ({r0_d, s1_tag}),
    .out_valid_o (s2_valid),
    .out_ready_i (s3_rdy),
    .out_data_o  (s2_data)
  );

  assign {s2_r0, s2_tag} = s2_data;

  // Final correction: subtract Q up to twice to land in [0, Q).
  always_comb begin
    t1 = s2_r0;
    if (t1 >= QV) t1 = t1 - QV;
    t2 = t1;
    if (t2 >= QV) t2 = t2 - QV;
    r_d = DOUT_W'(t2);
  end

  barret_stage #(.W(W3)) u_s3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s2_valid),
    .in_ready_o  (s3_rdy),
    .in_data_i   ({r_d, s2_tag}),
    .out_valid_o (dout_valid),
    .out_ready_i (dout_ready),
    .out_data_o  (s3_data)
  );

  assign {dout_r, dout_tag} = s3_data;

  // Count results taken by the consumer; wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (dout_valid && dout_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Completed-result counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_barret_pipe.sv
// Bench for barret_pipe: directed steps plus a random stream,
// checked against a queue of x % Q results.
module tb_barret_pipe;

  localparam int Q  = 3187;
  localparam int DW = 23;
  localparam int TW = 4;
  localparam int OW = 12;
  localparam int Q2 = 7681;
  localparam int DW2 = 25;
  localparam int OW2 = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          din_valid, din_ready;
  logic [DW-1:0] din_a;
  logic [TW-1:0] din_tag;
  logic          dout_valid, dout_ready;
  logic [OW-1:0] dout_r;
  logic [TW-1:0] dout_tag;
  logic [31:0]   done_cnt;

  logic           v2, rdy2, ov2, or2;
  logic [DW2-1:0] a2;
  logic [TW-1:0]  tag2, otag2;
  logic [OW2-1:0] r2;
  logic [2:0]     cnt2;

  barret_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_a      (din_a),
    .din_tag    (din_tag),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_r     (dout_r),
    .dout_tag   (dout_tag),
    .done_cnt   (done_cnt)
  );

  barret_pipe #(.Q(Q2), .DIN_W(DW2), .TAG_W(TW), .CNT_W(3)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (v2),
    .din_ready  (rdy2),
    .din_a      (a2),
    .din_tag    (tag2),
    .dout_valid (ov2),
    .dout_ready (or2),
    .dout_r     (r2),
    .dout_tag   (otag2),
    .done_cnt   (cnt2)
  );

  typedef struct {
    logic [OW-1:0] r;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic          stall_p = 1'b0;
  logic [OW-1:0] r_p;
  logic [TW-1:0] tag_p;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      dout_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: hold-stability while stalled, and scoreboard pops.
  always @(negedge clk) begin
    if (rst_n && stall_p) begin
      n_chk++;
      assert (dout_valid === 1'b1 && dout_r === r_p && dout_tag === tag_p)
      else begin
        n_fail++;
        $error("FAIL hold v=%0b r=%0d tag=%0d exp v=1 r=%0d tag=%0d",
               dout_valid, dout_r, dout_tag, r_p, tag_p);
      end
    end
    if (rst_n && dout_valid && dout_ready) begin
      n_chk++;
      assert (sbq.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_out r=%0d tag=%0d exp none", dout_r, dout_tag);
      end
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        n_chk++;
        assert (dout_r === mon_e.r && dout_tag === mon_e.tag)
        else begin
          n_fail++;
          $error("FAIL result r=%0d tag=%0d exp r=%0d tag=%0d",
                 dout_r, dout_tag, mon_e.r, mon_e.tag);
        end
        if (chk_lat) begin
          n_chk++;
          assert (cyc - mon_e.cyc == 3)
          else begin
            n_fail++;
            $error("FAIL latency got=%0d exp=3", cyc - mon_e.cyc);
          end
        end
      end
    end
    stall_p = rst_n && dout_valid && !dout_ready;
    r_p     = dout_r;
    tag_p   = dout_tag;
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [TW-1:0] t);
    int   w;
    exp_t e;
    din_valid = 1'b1;
    din_a     = x;
    din_tag   = t;
    w = 0;
    forever begin
      @(negedge clk);
      if (din_ready) begin
        e.r   = OW'(int'(x) % Q);
        e.tag = t;
        e.cyc = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      w++;
      if (w > 200) begin
        n_chk++;
        n_fail++;
        $error("FAIL send_timeout x=%0d waited=%0d exp<=200", x, w);
        break;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_left", sbq.size(), 0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    @(posedge clk);
    #1;
    check("rst_done_cnt", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run2(input logic [DW2-1:0] x, input logic [TW-1:0] t);
    int w;
    v2 = 1'b1;
    a2 = x;
    tag2 = t;
    @(negedge clk);
    check("q2_din_ready", rdy2, 1);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    w = 0;
    @(negedge clk);
    while (!ov2 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("q2_dout_valid", ov2, 1);
    check("q2_r", r2, longint'(x) % Q2);
    check("q2_tag", otag2, t);
    @(posedge clk);
    #1;
  endtask

  logic [OW-1:0] held;

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0;
    din_a = '0;
    din_tag = '0;
    dout_ready = 1'b1;
    v2 = 1'b0;
    a2 = '0;
    tag2 = '0;
    or2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_done_cnt0", done_cnt, 0);
    check("rst_dout_r", dout_r, 0);
    check("rst_dout_tag", dout_tag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_din_ready", din_ready, 1);
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    for (int i = 0; i <= 3187; i++) send(DW'(i), TW'(i));
    din_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("sweep_done_cnt", done_cnt, 3188);

    send(DW'(8388607), TW'(5));
    send(DW'(0), TW'(9));
    din_valid = 1'b0;
    drain();

    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(DW'(100 + i * 1000), TW'(i + 1));
    din_valid = 1'b1;
    din_a = DW'(5000);
    din_tag = TW'(4);
    @(negedge clk);
    check("stall_din_ready", din_ready, 0);
    check("stall_dout_valid", dout_valid, 1);
    check("stall_dout_r", dout_r, 100);
    held = dout_r;
    repeat (3) @(negedge clk);
    check("stall_hold_r", dout_r, held);
    check("stall_hold_rdy", din_ready, 0);
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    send(DW'(5000), TW'(4));
    send(DW'(6000000), TW'(5));
    send(DW'(3187 * 7), TW'(6));
    din_valid = 1'b0;
    drain();
    check("stall_done_cnt", done_cnt, 6);

    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(DW'(777 + i), TW'(i + 8));
    din_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_done_cnt", done_cnt, 0);
    check("midrst_din_ready", din_ready, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    check("midrst_rel_ready", din_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", dout_valid, 0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 9))
        0:       send(DW'(0), TW'($urandom));
        1:       send({DW{1'b1}}, TW'($urandom));
        default: send(DW'($urandom), TW'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b0;
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    drain();

    run2(DW2'(100000), TW'(3));
    run2(DW2'(33554431), TW'(7));
    run2(DW2'(0), TW'(1));
    for (int i = 0; i < 6; i++) run2(DW2'($urandom), TW'(i));
    check("q2_cnt_wrap", cnt2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
